ps2_key_decoder: RTL and testbench
==================================

# ps2_key_decoder

Receives the PS/2 keyboard serial stream, decodes make/break scan codes (including E0-extended and F0-break prefixes) and maintains the per-key pressed map consumed by the player movement controller and other game-control logic. It produces the `key_down` / `last_change` / `been_ready` event interface. Each completed key event raises a one-cycle `been_ready` strobe together with the updated key map. It sits between the board PS/2 pins and all keyboard-driven game logic.

## Interface

**Parameters**
- `KEY_BITS`, default 13: width of `key_down`. Covers indexes 0..12, which includes F1–F6 (codes 0x05, 0x06, 0x04, 0x0C, 0x03, 0x0B).
- `FILTER_LEN`, default 8: number of consecutive identical synchronized samples required before the filtered PS/2 clock changes.
- `TIMEOUT_CYCLES`, default 100000: cycles without a filtered falling edge after which a partial frame is abandoned.

**Ports**
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock; asynchronous to `clk`.
- `ps2_data`  in  1  raw PS/2 data; asynchronous to `clk`.
- `key_down`  out  KEY_BITS  bit i = 1 while the key with index i is held.
- `last_change`  out  9  index of the most recent event, `{extended, code[7:0]}`.
- `been_ready`  out  1  one-cycle strobe; `last_change` and `key_down` are updated in the same cycle.
- `frame_err`  out  1  one-cycle strobe on a parity error, bad start/stop bit, or timeout.

## Operation

**Input conditioning**
- `ps2_clk` and `ps2_data` each pass through a 2-flop synchronizer.
- The synchronized clock feeds a filter that flips only after `FILTER_LEN` consecutive agreeing samples. The filter resets to 1.
- A filtered 1→0 transition is a *fall* event. On a fall, synchronized `ps2_data` is sampled.

**Bit FSM**
- States: IDLE → DATA (8 bits, LSB first) → PARITY → STOP → IDLE.
- In IDLE, a fall with data = 0 is the start bit and moves to DATA. A fall with data = 1 stays in IDLE and sets `frame_err`.
- PARITY: odd parity over the 8 data bits plus the parity bit.
- STOP: requires data = 1.
- A parity or stop failure discards the byte, pulses `frame_err`, and clears the prefix flags.
- Timeout counter: resets on every fall and counts only outside IDLE. When it reaches `TIMEOUT_CYCLES`, the FSM returns to IDLE, `frame_err` pulses, and the prefix flags clear.

**Byte handling (valid byte)**
- 0xE0: set `ext`. No strobe.
- 0xF0: set `brk`. No strobe.
- Any other byte B:
  - `idx = {ext, B}`; `last_change <= idx`; `been_ready` pulses.
  - If `idx < KEY_BITS`: `key_down[idx] <= ~brk`.
  - Clear `ext` and `brk`.
- A repeated make of an already-held key (typematic repeat) still pulses `been_ready`; `key_down` does not change.
- Indexes ≥ KEY_BITS update `last_change` and pulse `been_ready`, but do not touch `key_down`.

**Reset**
- All outputs go to 0: `key_down = 0`, `last_change = 9'h000`, `been_ready = 0`, `frame_err = 0`.
- The FSM returns to IDLE, bit and timeout counters clear, `ext`/`brk` clear, and the filter output goes to 1.
- Reset asserted mid-frame abandons the frame with no strobe. Decoding resumes at the next start bit.

## Timing

- **Latency:** `been_ready`, `last_change` and `key_down` update in the cycle after the fall that samples the stop bit. That fall occurs 2 + FILTER_LEN cycles after the raw `ps2_clk` edge settles.
- **Strobes:**
  - `been_ready` is high for exactly 1 cycle per event and is never asserted in the same cycle as `frame_err`.
  - `frame_err` is high for exactly 1 cycle per error and is issued on the same cycle edge that `been_ready` would use.
- **Outputs:** registered. `key_down` and `last_change` hold between events.
- **Glitches:** `ps2_clk` glitches shorter than FILTER_LEN cycles produce no fall event and no bit.
- **Frame rate:** back-to-back frames at the 10–16.7 kHz PS/2 rate must decode without loss. The FSM is ready for the next start bit on the cycle after STOP.

## Test plan

1. **Make code:** frame 0x05 (parity 1) → one `been_ready` pulse; `last_change = 9'h005`; `key_down = 13'h0020`.
2. **Break code:** with key 0x05 held, frames F0, 05 → no strobe after F0; after 05, one pulse, `last_change = 9'h005`, `key_down[5] = 0`. Then 0x0C twice (typematic repeat) → two pulses; `key_down[12] = 1` throughout.
3. **Extended key:** frames E0, 75 → `last_change = 9'h175`, one pulse, `key_down` unchanged. Frames E0, F0, 75 → one pulse, `last_change = 9'h175`.
4. **Parity error:** 0x0C with even parity → `frame_err` pulse, no `been_ready`, `key_down` unchanged. Then F0 with a bad stop bit, followed by a valid 0x04 → 0x04 is treated as a make: `key_down[4] = 1`.
5. **Timeout:** start bit plus 5 data bits, then `ps2_clk` held high for TIMEOUT_CYCLES → one `frame_err` pulse; a following valid frame 0x06 decodes to `key_down[6] = 1`.
6. **Glitch and reset:** a `ps2_clk` low pulse of FILTER_LEN−1 cycles → no bit sampled. Then `rst` asserted after 4 data bits → all outputs 0, no strobe; a following 0x03 frame sets `key_down[3] = 1`.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: conditions the raw PS/2 clock/data, frames 11-bit bytes and
// decodes make/break/extended scan codes into a held-key map with event strobes.
//
// state    | meaning
// S_IDLE   | waiting for a start bit (fall with data = 0)
// S_DATA   | shifting in 8 data bits, LSB first
// S_PARITY | sampling the odd-parity bit
// S_STOP   | sampling the stop bit, then decoding the byte
module ps2_key_decoder #(
    parameter int KEY_BITS       = 13,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ps2_clk,
    input  logic                ps2_data,
    output logic [KEY_BITS-1:0] key_down,
    output logic [8:0]          last_change,
    output logic                been_ready,
    output logic                frame_err
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    localparam int FLT_W = $clog2(FILTER_LEN + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic                ck_s1_q, ck_s2_q, dt_s1_q, dt_s2_q;
    logic                filt_q, filt_d;
    logic [FLT_W-1:0]    flt_cnt_q, flt_cnt_d;
    logic [1:0]          state_q, state_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [7:0]          shift_q, shift_d;
    logic                par_ok_q, par_ok_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                ext_q, ext_d, brk_q, brk_d;
    logic [KEY_BITS-1:0] key_down_q, key_down_d;
    logic [8:0]          last_change_q, last_change_d;
    logic                been_ready_q, been_ready_d;
    logic                frame_err_q, frame_err_d;
    logic                fall, timeout;
    logic [8:0]          idx;

    always_comb begin
        filt_d        = filt_q;
        flt_cnt_d     = flt_cnt_q;
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        par_ok_d      = par_ok_q;
        tmo_d         = tmo_q;
        ext_d         = ext_q;
        brk_d         = brk_q;
        key_down_d    = key_down_q;
        last_change_d = last_change_q;
        been_ready_d  = 1'b0;
        frame_err_d   = 1'b0;
        fall          = 1'b0;
        timeout       = 1'b0;
        idx           = {ext_q, shift_q};

        // Filter flips on the FILTER_LEN-th consecutive sample that disagrees with it.
        if (ck_s2_q == filt_q) begin
            flt_cnt_d = '0;
        end else if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
            filt_d    = ~filt_q;
            flt_cnt_d = '0;
            fall      = filt_q;
        end else begin
            flt_cnt_d = flt_cnt_q + 1'b1;
        end

        if (fall || state_q == S_IDLE) begin
            tmo_d = '0;
        end else begin
            tmo_d   = tmo_q + 1'b1;
            timeout = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
        end

        if (timeout) begin
            state_d     = S_IDLE;
            tmo_d       = '0;
            frame_err_d = 1'b1;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
        end else if (fall) begin
            case (state_q)
                S_IDLE: begin
                    if (!dt_s2_q) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                S_DATA: begin
                    shift_d   = {dt_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_ok_d = ^{shift_q, dt_s2_q};
                    state_d  = S_STOP;
                end
                default: begin
                    state_d = S_IDLE;
                    if (!dt_s2_q || !par_ok_q) begin
                        frame_err_d = 1'b1;
                        ext_d       = 1'b0;
                        brk_d       = 1'b0;
                    end else if (shift_q == 8'hE0) begin
                        ext_d = 1'b1;
                    end else if (shift_q == 8'hF0) begin
                        brk_d = 1'b1;
                    end else begin
                        last_change_d = idx;
                        been_ready_d  = 1'b1;
                        for (int i = 0; i < KEY_BITS; i++) begin
                            if (idx == 9'(i)) key_down_d[i] = ~brk_q;
                        end
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ck_s1_q       <= 1'b1;
            ck_s2_q       <= 1'b1;
            dt_s1_q       <= 1'b1;
            dt_s2_q       <= 1'b1;
            filt_q        <= 1'b1;
            flt_cnt_q     <= '0;
            state_q       <= S_IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            par_ok_q      <= 1'b0;
            tmo_q         <= '0;
            ext_q         <= 1'b0;
            brk_q         <= 1'b0;
            key_down_q    <= '0;
            last_change_q <= '0;
            been_ready_q  <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            ck_s1_q       <= ps2_clk;
            ck_s2_q       <= ck_s1_q;
            dt_s1_q       <= ps2_data;
            dt_s2_q       <= dt_s1_q;
            filt_q        <= filt_d;
            flt_cnt_q     <= flt_cnt_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            par_ok_q      <= par_ok_d;
            tmo_q         <= tmo_d;
            ext_q         <= ext_d;
            brk_q         <= brk_d;
            key_down_q    <= key_down_d;
            last_change_q <= last_change_d;
            been_ready_q  <= been_ready_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign key_down    = key_down_q;
    assign last_change = last_change_q;
    assign been_ready  = been_ready_q;
    assign frame_err   = frame_err_q;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed scan-code scenarios plus random frames checked
// against a byte-level key-map model.
module tb_ps2_key_decoder;
    localparam int KB  = 13;
    localparam int FL  = 8;
    localparam int TMO = 400;
    localparam int H   = 25;

    logic          clk = 1'b0;
    logic          rst, ps2_clk, ps2_data;
    logic [KB-1:0] key_down;
    logic [8:0]    last_change;
    logic          been_ready, frame_err;

    int n_vec = 0, n_err = 0;
    int br_cnt = 0, fe_cnt = 0;

    bit       km [0:511];
    bit       m_ext, m_brk;
    logic [8:0] m_lc;

    ps2_key_decoder #(.KEY_BITS(KB), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key_down(key_down), .last_change(last_change),
        .been_ready(been_ready), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (been_ready) br_cnt++;
            if (frame_err) fe_cnt++;
            if (been_ready || frame_err) chk("strobe_excl", {31'b0, been_ready & frame_err}, 0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [KB-1:0] model_keys();
        logic [KB-1:0] v;
        for (int i = 0; i < KB; i++) v[i] = km[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 512; i++) km[i] = 1'b0;
        m_ext = 1'b0;
        m_brk = 1'b0;
        m_lc  = '0;
    endtask

    // Returns the expected number of been_ready / frame_err strobes for one received byte.
    task automatic model_byte(input logic [7:0] b, input bit ok, output int dbr, output int dfe);
        int k;
        dbr = 0;
        dfe = 0;
        if (!ok) begin
            dfe = 1; m_ext = 0; m_brk = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            k    = m_ext * 256 + b;
            m_lc = 9'(k);
            dbr  = 1;
            if (k < KB) km[k] = !m_brk;
            m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic check_all(input string tag, input int dbr_got, input int dfe_got,
                             input int dbr_exp, input int dfe_exp);
        chk({tag, "_br"}, dbr_got, dbr_exp);
        chk({tag, "_fe"}, dfe_got, dfe_exp);
        chk({tag, "_lc"}, last_change, m_lc);
        chk({tag, "_keys"}, key_down, model_keys());
    endtask

    task automatic ps2_bit(input bit b);
        ps2_data = b;
        cyc(H);
        ps2_clk = 1'b0;
        cyc(H);
        ps2_clk = 1'b1;
    endtask

    task automatic send(input string tag, input logic [7:0] b, input bit par_ok, input bit stop_ok);
        int br0, fe0, dbr, dfe;
        br0 = br_cnt;
        fe0 = fe_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ !par_ok);
        ps2_bit(stop_ok);
        ps2_data = 1'b1;
        cyc(H);
        model_byte(b, par_ok && stop_ok, dbr, dfe);
        check_all(tag, br_cnt - br0, fe_cnt - fe0, dbr, dfe);
    endtask

    initial begin
        int br0, fe0, r;
        logic [7:0] b;
        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
        model_reset();
        cyc(5);
        rst = 1'b0;
        cyc(2);
        check_all("reset", br_cnt, fe_cnt, 0, 0);

        send("make05", 8'h05, 1, 1);
        send("brk_f0", 8'hF0, 1, 1);
        send("brk05", 8'h05, 1, 1);
        send("make0c", 8'h0C, 1, 1);
        send("rep0c", 8'h0C, 1, 1);
        send("ext_e0", 8'hE0, 1, 1);
        send("ext75", 8'h75, 1, 1);
        send("xb_e0", 8'hE0, 1, 1);
        send("xb_f0", 8'hF0, 1, 1);
        send("xb75", 8'h75, 1, 1);
        send("par_err", 8'h0C, 0, 1);
        send("stop_err", 8'hF0, 1, 0);
        send("make04", 8'h04, 1, 1);

        // partial frame, then silence until the timeout fires
        br0 = br_cnt; fe0 = fe_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'($urandom_range(0, 1)));
        ps2_data = 1'b1;
        cyc(TMO + 3 * H);
        m_ext = 0; m_brk = 0;
        check_all("timeout", br_cnt - br0, fe_cnt - fe0, 0, 1);
        send("make06", 8'h06, 1, 1);

        // sub-filter glitch with data low must not look like a start bit
        br0 = br_cnt; fe0 = fe_cnt;
        ps2_data = 1'b0;
        cyc(H);
        ps2_clk = 1'b0;
        cyc(FL - 1);
        ps2_clk = 1'b1;
        cyc(H);
        ps2_data = 1'b1;
        cyc(2 * H);
        check_all("glitch", br_cnt - br0, fe_cnt - fe0, 0, 0);
        send("post_glitch", 8'h0B, 1, 1);

        // reset in the middle of a frame
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)));
        ps2_data = 1'b1;
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        model_reset();
        br0 = br_cnt; fe0 = fe_cnt;
        cyc(4 * H);
        check_all("mid_rst", br_cnt - br0, fe_cnt - fe0, 0, 0);
        send("make03", 8'h03, 1, 1);

        for (int n = 0; n < 70; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0:       b = 8'hE0;
                1:       b = 8'hF0;
                2, 3, 4, 5: b = 8'($urandom_range(0, 15));
                6:       b = 8'h75;
                default: b = 8'($urandom_range(0, 255));
            endcase
            send("rand", b, $urandom_range(0, 11) != 0, $urandom_range(0, 13) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
